// File: rtl/deserializer.sv
// Serial-to-parallel receive stage: rebuilds MSB-first bit streams into left-justified words,
// emitting full words after DATA_W bits and flushing partial words after an idle gap.
module deserializer #(
    parameter int DATA_W      = 16,
    parameter int GAP_TIMEOUT = 4
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic                      ser_data_i,
    input  logic                      ser_data_val_i,
    output logic [DATA_W-1:0]         deser_data_o,
    output logic [$clog2(DATA_W):0]   deser_len_o,
    output logic                      deser_data_val_o
);

    localparam int CNT_W    = $clog2(DATA_W);
    localparam int LEN_W    = CNT_W + 1;
    localparam int GAP_W    = 8;
    localparam int GAP_LAST = (GAP_TIMEOUT > 0) ? GAP_TIMEOUT - 1 : 0;

    logic [DATA_W-1:0] r_sh;
    logic [CNT_W-1:0]  r_cnt;
    logic [GAP_W-1:0]  r_gap;
    logic [DATA_W-1:0] r_data;
    logic [LEN_W-1:0]  r_len;
    logic              r_val;

    logic [DATA_W-1:0] w_sh_next;
    logic              w_word_done;
    logic              w_idle_pending;
    logic              w_flush;
    logic [LEN_W-1:0]  w_shamt;
    logic [DATA_W-1:0] w_flush_data;

    assign w_sh_next      = {r_sh[DATA_W-2:0], ser_data_i};
    assign w_word_done    = ser_data_val_i && (r_cnt == CNT_W'(DATA_W - 1));
    // Idle cycles only count while a partial word is pending and flushing is enabled.
    assign w_idle_pending = !ser_data_val_i && (r_cnt != '0) && (GAP_TIMEOUT > 0);
    assign w_flush        = w_idle_pending && (r_gap == GAP_W'(GAP_LAST));
    assign w_shamt        = LEN_W'(DATA_W) - {1'b0, r_cnt};
    assign w_flush_data   = r_sh << w_shamt;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_gap  <= '0;
            r_data <= '0;
            r_len  <= '0;
            r_val  <= 1'b0;
        end else begin
            r_val <= 1'b0;
            if (ser_data_val_i) begin
                r_sh  <= w_sh_next;
                r_gap <= '0;
                if (w_word_done) begin
                    r_data <= w_sh_next;
                    r_len  <= LEN_W'(DATA_W);
                    r_val  <= 1'b1;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_flush) begin
                r_data <= w_flush_data;
                r_len  <= {1'b0, r_cnt};
                r_val  <= 1'b1;
                r_cnt  <= '0;
                r_gap  <= '0;
            end else if (w_idle_pending) begin
                r_gap <= r_gap + 1'b1;
            end
        end
    end

    assign deser_data_o     = r_data;
    assign deser_len_o      = r_len;
    assign deser_data_val_o = r_val;

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: directed and random bit streams checked against a bit-list reference model.
module tb_deserializer;

    localparam int DATA_W = 16;
    localparam int GAP    = 4;

    logic              clk = 1'b0;
    logic              arst = 1'b1;
    logic              ser_d = 1'b0;
    logic              ser_v = 1'b0;
    logic [DATA_W-1:0] dout;
    logic [4:0]        dlen;
    logic              dval;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit                stim_v[$];
    bit                stim_d[$];
    logic [DATA_W-1:0] exp_d_q[$];
    int                exp_l_q[$];
    int                exp_c_q[$];
    logic [DATA_W-1:0] obs_d_q[$];
    int                obs_l_q[$];
    int                obs_c_q[$];

    deserializer #(.DATA_W(DATA_W), .GAP_TIMEOUT(GAP)) dut (
        .clk_i            (clk),
        .arst_i           (arst),
        .ser_data_i       (ser_d),
        .ser_data_val_i   (ser_v),
        .deser_data_o     (dout),
        .deser_len_o      (dlen),
        .deser_data_val_o (dval)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (dval === 1'b1) begin
            obs_d_q.push_back(dout);
            obs_l_q.push_back(int'(dlen));
            obs_c_q.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

    task automatic push_word(input logic [DATA_W-1:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            stim_v.push_back(1'b1);
            stim_d.push_back(w[DATA_W-1-i]);
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) begin
            stim_v.push_back(1'b0);
            stim_d.push_back(1'($urandom_range(0, 1)));
        end
    endtask

    // Reference: keep a list of pending bits; a word leaves when it holds DATA_W bits
    // or after GAP consecutive idle cycles with bits pending.
    task automatic build_expected(input int base);
        bit pend[$];
        int idle;
        logic [DATA_W-1:0] w;
        idle = 0;
        exp_d_q.delete(); exp_l_q.delete(); exp_c_q.delete();
        for (int k = 0; k < stim_v.size(); k++) begin
            if (stim_v[k]) begin
                pend.push_back(stim_d[k]);
                idle = 0;
                if (pend.size() == DATA_W) begin
                    for (int b = 0; b < DATA_W; b++) w[DATA_W-1-b] = pend[b];
                    exp_d_q.push_back(w); exp_l_q.push_back(DATA_W); exp_c_q.push_back(base + k + 1);
                    pend.delete();
                end
            end else if (pend.size() > 0) begin
                idle++;
                if (idle == GAP) begin
                    w = '0;
                    for (int b = 0; b < pend.size(); b++) w[DATA_W-1-b] = pend[b];
                    exp_d_q.push_back(w); exp_l_q.push_back(pend.size()); exp_c_q.push_back(base + k + 1);
                    pend.delete();
                    idle = 0;
                end
            end
        end
    endtask

    // Drives the stimulus lists (plus a trailing idle tail) one entry per cycle.
    task automatic run_stim();
        int base;
        push_idle(GAP + 4);
        @(negedge clk);
        base = cyc;
        build_expected(base);
        obs_d_q.delete(); obs_l_q.delete(); obs_c_q.delete();
        for (int k = 0; k < stim_v.size(); k++) begin
            ser_v = stim_v[k];
            ser_d = stim_d[k];
            @(negedge clk);
        end
        ser_v = 1'b0;
        ser_d = 1'b0;
        stim_v.delete();
        stim_d.delete();
    endtask

    task automatic test_reset();
        checks++;
        if (dout !== 16'h0 || dlen !== 5'd0 || dval !== 1'b0) begin
            errors++;
            $display("FAIL reset_during got d=%h l=%0d v=%b exp 0/0/0", dout, dlen, dval);
        end
        repeat (3) @(negedge clk);
        arst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dout !== 16'h0 || dlen !== 5'd0 || dval !== 1'b0) begin
            errors++;
            $display("FAIL reset_after got d=%h l=%0d v=%b exp 0/0/0", dout, dlen, dval);
        end
    endtask

    task automatic test_full_word();
        push_word(16'hA5C3, 16);
        run_stim();
        checks++;
        if (obs_d_q.size() != exp_d_q.size()) begin
            errors++; $display("FAIL full_count got %0d exp %0d", obs_d_q.size(), exp_d_q.size());
        end
        for (int i = 0; i < exp_d_q.size() && i < obs_d_q.size(); i++) begin
            checks++;
            if (obs_d_q[i] !== exp_d_q[i] || obs_l_q[i] != exp_l_q[i] || obs_c_q[i] != exp_c_q[i]) begin
                errors++;
                $display("FAIL full[%0d] got d=%h l=%0d c=%0d exp d=%h l=%0d c=%0d", i,
                         obs_d_q[i], obs_l_q[i], obs_c_q[i], exp_d_q[i], exp_l_q[i], exp_c_q[i]);
            end
        end
        checks++;
        if (obs_d_q.size() < 1 || obs_d_q[0] !== 16'hA5C3 || obs_l_q[0] != 16) begin
            errors++; $display("FAIL full_const got %0d pulses exp d=a5c3 l=16", obs_d_q.size());
        end
    endtask

    task automatic test_back_to_back();
        push_word(16'h1234, 16);
        push_word(16'hFFFF, 16);
        run_stim();
        checks++;
        if (obs_d_q.size() != exp_d_q.size()) begin
            errors++; $display("FAIL b2b_count got %0d exp %0d", obs_d_q.size(), exp_d_q.size());
        end
        for (int i = 0; i < exp_d_q.size() && i < obs_d_q.size(); i++) begin
            checks++;
            if (obs_d_q[i] !== exp_d_q[i] || obs_l_q[i] != exp_l_q[i] || obs_c_q[i] != exp_c_q[i]) begin
                errors++;
                $display("FAIL b2b[%0d] got d=%h l=%0d c=%0d exp d=%h l=%0d c=%0d", i,
                         obs_d_q[i], obs_l_q[i], obs_c_q[i], exp_d_q[i], exp_l_q[i], exp_c_q[i]);
            end
        end
        checks++;
        if (obs_c_q.size() != 2 || (obs_c_q[1] - obs_c_q[0]) != 16) begin
            errors++; $display("FAIL b2b_spacing got %0d pulses exp 2 pulses 16 cycles apart", obs_c_q.size());
        end
    endtask

    task automatic test_gap_tolerant();
        logic [DATA_W-1:0] w;
        w = 16'h8001;
        for (int i = 0; i < DATA_W; i++) begin
            stim_v.push_back(1'b1);
            stim_d.push_back(w[DATA_W-1-i]);
            if (i != DATA_W - 1) push_idle(1);
        end
        run_stim();
        checks++;
        if (obs_d_q.size() != 1 || exp_d_q.size() != 1) begin
            errors++; $display("FAIL gap_count got %0d exp 1", obs_d_q.size());
        end
        for (int i = 0; i < exp_d_q.size() && i < obs_d_q.size(); i++) begin
            checks++;
            if (obs_d_q[i] !== exp_d_q[i] || obs_l_q[i] != exp_l_q[i] || obs_c_q[i] != exp_c_q[i]
                || obs_d_q[i] !== 16'h8001) begin
                errors++;
                $display("FAIL gap[%0d] got d=%h l=%0d c=%0d exp d=%h l=%0d c=%0d", i,
                         obs_d_q[i], obs_l_q[i], obs_c_q[i], exp_d_q[i], exp_l_q[i], exp_c_q[i]);
            end
        end
    endtask

    task automatic test_partial_flush();
        push_word(16'hB000, 5);
        push_idle(GAP);
        push_idle(1);
        run_stim();
        checks++;
        if (obs_d_q.size() != 1 || exp_d_q.size() != 1) begin
            errors++; $display("FAIL partial_count got %0d exp 1", obs_d_q.size());
        end
        for (int i = 0; i < exp_d_q.size() && i < obs_d_q.size(); i++) begin
            checks++;
            if (obs_d_q[i] !== exp_d_q[i] || obs_l_q[i] != exp_l_q[i] || obs_c_q[i] != exp_c_q[i]
                || obs_d_q[i] !== 16'hB000 || obs_l_q[i] != 5) begin
                errors++;
                $display("FAIL partial[%0d] got d=%h l=%0d c=%0d exp d=%h l=%0d c=%0d", i,
                         obs_d_q[i], obs_l_q[i], obs_c_q[i], exp_d_q[i], exp_l_q[i], exp_c_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        logic [DATA_W-1:0] w;
        w = 16'h5A5A;
        obs_d_q.delete(); obs_l_q.delete(); obs_c_q.delete();
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            ser_v = 1'b1;
            ser_d = w[DATA_W-1-i];
            @(negedge clk);
        end
        ser_v = 1'b0;
        #2 arst = 1'b1;
        #1;
        checks++;
        if (dout !== 16'h0 || dlen !== 5'd0 || dval !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async got d=%h l=%0d v=%b exp 0/0/0", dout, dlen, dval);
        end
        repeat (2) @(negedge clk);
        arst = 1'b0;
        repeat (GAP + 8) @(negedge clk);
        checks++;
        if (obs_d_q.size() != 0) begin
            errors++; $display("FAIL rst_mid_nopulse got %0d pulses exp 0", obs_d_q.size());
        end
        push_word(16'h00FF, 16);
        run_stim();
        checks++;
        if (obs_d_q.size() != 1 || obs_d_q[0] !== 16'h00FF || obs_l_q[0] != 16
            || exp_c_q.size() != 1 || obs_c_q[0] != exp_c_q[0]) begin
            errors++; $display("FAIL rst_mid_next got %0d pulses exp one d=00ff l=16", obs_d_q.size());
        end
    endtask

    // Emulates the upstream serializer: data_mod 0 sends all bits, otherwise the top data_mod bits.
    task automatic test_serializer_chain();
        int mods[2] = '{0, 5};
        logic [DATA_W-1:0] cexp[2] = '{16'hBEEF, 16'hB800};
        int lexp[2] = '{16, 5};
        for (int t = 0; t < 2; t++) begin
            push_word(16'hBEEF, (mods[t] == 0) ? DATA_W : mods[t]);
            run_stim();
            checks++;
            if (obs_d_q.size() != 1 || exp_c_q.size() != 1) begin
                errors++; $display("FAIL chain%0d_count got %0d exp 1", t, obs_d_q.size());
            end else begin
                checks++;
                if (obs_d_q[0] !== cexp[t] || obs_l_q[0] != lexp[t] || obs_c_q[0] != exp_c_q[0]) begin
                    errors++;
                    $display("FAIL chain%0d got d=%h l=%0d c=%0d exp d=%h l=%0d c=%0d", t,
                             obs_d_q[0], obs_l_q[0], obs_c_q[0], cexp[t], lexp[t], exp_c_q[0]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            for (int k = 0; k < 150; k++) begin
                if ($urandom_range(0, 19) == 0) push_idle($urandom_range(GAP - 1, GAP + 3));
                else if ($urandom_range(0, 3) == 0) push_idle(1);
                else begin
                    stim_v.push_back(1'b1);
                    stim_d.push_back(1'($urandom_range(0, 1)));
                end
            end
            run_stim();
            checks++;
            if (obs_d_q.size() != exp_d_q.size()) begin
                errors++; $display("FAIL rand%0d_count got %0d exp %0d", it, obs_d_q.size(), exp_d_q.size());
            end
            for (int i = 0; i < exp_d_q.size() && i < obs_d_q.size(); i++) begin
                checks++;
                if (obs_d_q[i] !== exp_d_q[i] || obs_l_q[i] != exp_l_q[i] || obs_c_q[i] != exp_c_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d[%0d] got d=%h l=%0d c=%0d exp d=%h l=%0d c=%0d", it, i,
                             obs_d_q[i], obs_l_q[i], obs_c_q[i], exp_d_q[i], exp_l_q[i], exp_c_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_back_to_back();
        test_gap_tolerant();
        test_partial_flush();
        test_reset_mid_word();
        test_serializer_chain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
